// File: rtl/hazard_ctrl_unit.sv
// Hazard/stall/forward controller for the 5-stage RV32I pipeline (branches resolve in ID).
// Optional feature macro: STORE_FWD_EN enables the load-to-store WB->MEM data forward.
module hazard_ctrl_unit #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [1:0]        id_optype,
    input  logic              id_rs1use,
    input  logic              id_rs2use,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_muldiv,
    input  logic              id_branch,
    input  logic              mem_ready,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              flush_ifid,
    output logic              stall_idex,
    output logic              flush_idex,
    output logic              stall_exmem,
    output logic              flush_exmem,
    output logic              flush_memwb,
    output logic [1:0]        fwd_rs1_sel,
    output logic [1:0]        fwd_rs2_sel,
    output logic              fwd_store_wb
);

    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;
    localparam logic [CNT_W-1:0] MD_LOAD_VAL = CNT_W'(MD_LAT - 1);

    typedef struct packed {
        logic              valid;
        logic [1:0]        optype;
        logic [REG_AW-1:0] rd;
    } stage_t;

    stage_t           ex_q;
    stage_t           mem_q;
    logic [CNT_W-1:0] md_cnt;

    logic ex_m1, ex_m2, mem_m1, mem_m2;
    logic mem_wait, md_hold, load_use, store_exempt, ex_load_en;

    function automatic logic stage_match(stage_t s, logic [REG_AW-1:0] rs, logic use_b);
        return s.valid && (s.optype == OP_ALU || s.optype == OP_LOAD) &&
               (s.rd == rs) && (rs != '0) && use_b;
    endfunction

    // Nearest stage wins; an EX hit that cannot forward yields the regfile path while ID is held.
    function automatic logic [1:0] fwd_sel(logic ex_hit, logic mem_hit, logic ex_ok, logic mem_alu);
        if (ex_hit)
            return ex_ok ? 2'd1 : 2'd0;
        else if (mem_hit)
            return mem_alu ? 2'd2 : 2'd3;
        else
            return 2'd0;
    endfunction

    assign ex_m1  = stage_match(ex_q,  id_rs1, id_valid && id_rs1use);
    assign ex_m2  = stage_match(ex_q,  id_rs2, id_valid && id_rs2use);
    assign mem_m1 = stage_match(mem_q, id_rs1, id_valid && id_rs1use);
    assign mem_m2 = stage_match(mem_q, id_rs2, id_valid && id_rs2use);

    assign mem_wait = mem_q.valid && mem_q.optype[1] && !mem_ready;
    assign md_hold  = (md_cnt != '0);
    assign load_use = (ex_q.optype == OP_LOAD) && (ex_m1 || ex_m2) && !store_exempt;

    assign fwd_rs1_sel = fwd_sel(ex_m1, mem_m1, (ex_q.optype == OP_ALU) && !md_hold,
                                 mem_q.optype == OP_ALU);
    assign fwd_rs2_sel = fwd_sel(ex_m2, mem_m2, (ex_q.optype == OP_ALU) && !md_hold,
                                 mem_q.optype == OP_ALU);

    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        flush_ifid  = 1'b0;
        stall_idex  = 1'b0;
        flush_idex  = 1'b0;
        stall_exmem = 1'b0;
        flush_exmem = 1'b0;
        flush_memwb = 1'b0;
        if (mem_wait) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            flush_memwb = 1'b1;
        end else if (md_hold) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            flush_exmem = 1'b1;
        end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            flush_idex  = 1'b1;
        end else if (id_branch && id_valid) begin
            flush_ifid  = 1'b1;
        end
    end

    assign ex_load_en = !stall_idex && !flush_idex;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q   <= '0;
            mem_q  <= '0;
            md_cnt <= '0;
        end else begin
            if (ex_load_en)
                ex_q <= '{valid: id_valid, optype: id_optype, rd: id_rd};
            else if (flush_idex)
                ex_q <= '0;

            if (flush_exmem)
                mem_q <= '0;
            else if (!stall_exmem)
                mem_q <= ex_q;

            // Counter frozen while memory waits; it can only reload once it has drained.
            if (!mem_wait) begin
                if (md_hold)
                    md_cnt <= md_cnt - CNT_W'(1);
                else if (ex_load_en && id_valid && id_muldiv)
                    md_cnt <= MD_LOAD_VAL;
            end
        end
    end

`ifdef STORE_FWD_EN
    stage_t            wb_q;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] mem_rs2;

    assign store_exempt = (id_optype == OP_STORE) && ex_m2 && !ex_m1;
    assign fwd_store_wb = mem_q.valid && (mem_q.optype == OP_STORE) && wb_q.valid &&
                          (wb_q.optype == OP_LOAD) && (wb_q.rd == mem_rs2) && (mem_rs2 != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q    <= '0;
            ex_rs2  <= '0;
            mem_rs2 <= '0;
        end else begin
            if (ex_load_en)
                ex_rs2 <= id_rs2;
            if (!stall_exmem)
                mem_rs2 <= ex_rs2;
            wb_q <= flush_memwb ? '0 : mem_q;
        end
    end
`else
    assign store_exempt = 1'b0;
    assign fwd_store_wb = 1'b0;
`endif

    always @(posedge clk) begin
        if (!rst) begin
            assert (MD_LAT >= 1 && MD_LAT < (1 << CNT_W));
            assert (md_cnt <= MD_LOAD_VAL);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed + randomized bench for hazard_ctrl_unit against a stage-occupancy reference model.
module tb_hazard_ctrl_unit;

    localparam int MD_LAT = 4;
`ifdef STORE_FWD_EN
    localparam bit SFWD = 1'b1;
`else
    localparam bit SFWD = 1'b0;
`endif

    localparam int ACT_RUN  = 0;
    localparam int ACT_WAIT = 1;
    localparam int ACT_MD   = 2;
    localparam int ACT_LDU  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1use, id_rs2use, id_muldiv, id_branch, mem_ready;
    logic [1:0] id_optype;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex;
    logic       stall_exmem, flush_exmem, flush_memwb, fwd_store_wb;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .MD_LAT(MD_LAT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_optype(id_optype),
        .id_rs1use(id_rs1use), .id_rs2use(id_rs2use), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_muldiv(id_muldiv), .id_branch(id_branch), .mem_ready(mem_ready),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
        .stall_idex(stall_idex), .flush_idex(flush_idex), .stall_exmem(stall_exmem),
        .flush_exmem(flush_exmem), .flush_memwb(flush_memwb), .fwd_rs1_sel(fwd_rs1_sel),
        .fwd_rs2_sel(fwd_rs2_sel), .fwd_store_wb(fwd_store_wb)
    );

    // Model: which instruction occupies each downstream stage, plus remaining mul/div hold cycles.
    typedef struct packed {
        logic       v;
        logic [1:0] op;
        logic [4:0] rd;
        logic [4:0] rs2;
    } prec_t;

    prec_t      p_ex, p_mem, p_wb;
    int         md_left;
    int         act;
    logic [7:0] exp_ctl;
    logic [4:0] exp_fw;
    int         n_asserts = 0;
    int         n_fail = 0;

    function automatic logic produces(prec_t r, logic [4:0] rs, logic use_b);
        return id_valid && use_b && r.v && (r.op == 2'b01 || r.op == 2'b10) &&
               (r.rd == rs) && (rs != 5'd0);
    endfunction

    function automatic logic [1:0] pick(logic ex_hit, logic mem_hit);
        if (ex_hit) return (p_ex.op == 2'b01 && md_left == 0) ? 2'd1 : 2'd0;
        if (mem_hit) return (p_mem.op == 2'b01) ? 2'd2 : 2'd3;
        return 2'd0;
    endfunction

    task automatic model_eval();
        logic d1_ex, d2_ex, d1_mem, d2_mem, ld_dep, exempt, st_wb;
        d1_ex  = produces(p_ex,  id_rs1, id_rs1use);
        d2_ex  = produces(p_ex,  id_rs2, id_rs2use);
        d1_mem = produces(p_mem, id_rs1, id_rs1use);
        d2_mem = produces(p_mem, id_rs2, id_rs2use);
        ld_dep = (p_ex.op == 2'b10) && (d1_ex || d2_ex);
        exempt = SFWD && (id_optype == 2'b11) && d2_ex && !d1_ex;
        if (p_mem.v && (p_mem.op == 2'b10 || p_mem.op == 2'b11) && !mem_ready) act = ACT_WAIT;
        else if (md_left > 0) act = ACT_MD;
        else if (ld_dep && !exempt) act = ACT_LDU;
        else act = ACT_RUN;
        // {stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex, stall_exmem, flush_exmem, flush_memwb}
        case (act)
            ACT_WAIT: exp_ctl = 8'b1101_0101;
            ACT_MD:   exp_ctl = 8'b1101_0010;
            ACT_LDU:  exp_ctl = 8'b1100_1000;
            default:  exp_ctl = {2'b00, id_branch && id_valid, 5'b00000};
        endcase
        st_wb = SFWD && p_mem.v && p_mem.op == 2'b11 && p_wb.v && p_wb.op == 2'b10 &&
                p_wb.rd == p_mem.rs2 && p_mem.rs2 != 5'd0;
        exp_fw = {pick(d1_ex, d1_mem), pick(d2_ex, d2_mem), st_wb};
    endtask

    task automatic model_step();
        prec_t bubble;
        bubble = '0;
        if (rst) begin
            p_ex = bubble; p_mem = bubble; p_wb = bubble; md_left = 0;
        end else begin
            case (act)
                ACT_WAIT: p_wb = bubble;
                ACT_MD: begin
                    p_wb = p_mem; p_mem = bubble; md_left = md_left - 1;
                end
                ACT_LDU: begin
                    p_wb = p_mem; p_mem = p_ex; p_ex = bubble;
                end
                default: begin
                    p_wb = p_mem; p_mem = p_ex;
                    p_ex = '{v: id_valid, op: id_optype, rd: id_rd, rs2: id_rs2};
                    if (id_valid && id_muldiv) md_left = MD_LAT - 1;
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ctl_vec();
        return {stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex,
                stall_exmem, flush_exmem, flush_memwb};
    endfunction

    task automatic cyc();
        @(negedge clk);
        model_eval();
        chk("ctl_model", 16'(ctl_vec()), 16'(exp_ctl));
        chk("fwd_model", 16'({fwd_rs1_sel, fwd_rs2_sel, fwd_store_wb}), 16'(exp_fw));
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [1:0] op, input logic u1, input logic u2,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic md, input logic br);
        id_valid = v; id_optype = op; id_rs1use = u1; id_rs2use = u2;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_muldiv = md; id_branch = br;
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b1;
        set_id(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        p_ex = '0; p_mem = '0; p_wb = '0; md_left = 0; act = ACT_RUN;
        repeat (2) @(posedge clk);
        #1;
        cyc();
        chk("reset_ctl", 16'(ctl_vec()), 16'd0);
        adv();
        rst = 1'b0;

        // 1: ALU producer forwarded from EX, then from MEM
        set_id(1, 2'b01, 0, 0, 0, 0, 5, 0, 0); cyc(); adv();
        set_id(1, 2'b01, 1, 0, 5, 0, 9, 0, 0); cyc(); chk("t1_ex_fwd", 16'(fwd_rs1_sel), 16'd1); adv();
        set_id(1, 2'b01, 1, 0, 5, 0, 10, 0, 0); cyc(); chk("t1_mem_fwd", 16'(fwd_rs1_sel), 16'd2); adv();

        // 2: load-use bubble then load-data forward
        set_id(1, 2'b10, 1, 0, 1, 0, 6, 0, 0); cyc(); adv();
        set_id(1, 2'b01, 0, 1, 0, 6, 11, 0, 0); cyc(); chk("t2_ldu", 16'(ctl_vec()), 16'h00c8); adv();
        cyc(); chk("t2_fwd3", 16'(fwd_rs2_sel), 16'd3); chk("t2_noldu", 16'(ctl_vec()), 16'd0); adv();

        // 3: multi-cycle EX hold
        set_id(1, 2'b01, 0, 0, 0, 0, 7, 1, 0); cyc(); adv();
        set_id(1, 2'b01, 1, 0, 7, 0, 12, 0, 0);
        repeat (MD_LAT - 1) begin
            cyc(); chk("t3_hold", 16'(ctl_vec()), 16'h00d2); adv();
        end
        cyc(); chk("t3_fwd", 16'(fwd_rs1_sel), 16'd1); chk("t3_release", 16'(ctl_vec()), 16'd0); adv();

        // 4: memory wait freeze
        set_id(1, 2'b10, 0, 0, 0, 0, 13, 0, 0); cyc(); adv();
        set_id(0, 2'b00, 0, 0, 0, 0, 0, 0, 0); cyc(); adv();
        mem_ready = 1'b0;
        repeat (2) begin
            cyc(); chk("t4_wait", 16'(ctl_vec()), 16'h00d5); adv();
        end
        mem_ready = 1'b1;
        cyc(); chk("t4_resume", 16'(ctl_vec()), 16'd0); adv();

        // 5: branch flush, deferred under load-use
        set_id(1, 2'b01, 0, 0, 0, 0, 0, 0, 1); cyc(); chk("t5_br", 16'(ctl_vec()), 16'h0020); adv();
        set_id(1, 2'b10, 0, 0, 0, 0, 14, 0, 0); cyc(); adv();
        set_id(1, 2'b00, 1, 0, 14, 0, 0, 0, 1);
        cyc(); chk("t5_br_stall", 16'(ctl_vec()), 16'h00c8); adv();
        cyc(); chk("t5_br_late", 16'(ctl_vec()), 16'h0020); adv();

        // 6: load followed by store of the loaded register
        set_id(1, 2'b10, 0, 0, 0, 0, 8, 0, 0); cyc(); adv();
        set_id(1, 2'b11, 1, 1, 0, 8, 0, 0, 0);
        cyc(); chk("t6_store_ldu", 16'(ctl_vec()), SFWD ? 16'd0 : 16'h00c8); adv();
        repeat (SFWD ? 1 : 2) begin
            cyc(); adv();
        end
        set_id(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        cyc(); chk("t6_store_fwd", 16'(fwd_store_wb), 16'(SFWD)); adv();

        // reset while a mul/div hold is pending
        set_id(1, 2'b01, 0, 0, 0, 0, 7, 1, 0); cyc(); adv();
        set_id(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1; cyc(); adv(); rst = 1'b0;
        set_id(1, 2'b01, 1, 0, 7, 0, 0, 0, 0);
        cyc(); chk("rst_mid_hold", 16'({ctl_vec(), fwd_rs1_sel}), 16'd0); adv();

        // randomized traffic on a small register set to provoke hazards
        for (int i = 0; i < 600; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            set_id(1'($urandom_range(0, 7) != 0), op, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), (op == 2'b01) && ($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 3) == 0));
            mem_ready = 1'($urandom_range(0, 3) != 0);
            rst = 1'($urandom_range(0, 63) == 0);
            cyc();
            adv();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
